// File: rtl/instr_mem_stream.sv
// instr_mem_stream: instruction memory filled by a streaming load FSM and
// read through a fixed-latency fetch port that only serves data in RUN.
//
// Load handshake: a word is transferred on every rising edge where
// ld_valid && ld_ready are both high. ld_ready is high for the whole of the
// LOAD state and depends on nothing else, so the loader may hold ld_valid
// high and stream one word per cycle. load_abort in the same cycle wins and
// the word is dropped.
module instr_mem_stream #(
    parameter int                 DATA_W   = 32,
    parameter int                 DEPTH    = 256,
    parameter int                 ADDR_W   = 32,
    parameter int                 READ_LAT = 1,
    parameter logic [DATA_W-1:0]  NOP_WORD = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              load_abort,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [ADDR_W-1:0] load_len,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_err,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_err,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

    state_t            state, state_n;
    logic [ADDR_W-1:0] ptr, ptr_n;
    logic [ADDR_W-1:0] cnt, cnt_n;
    logic [ADDR_W-1:0] len_q, len_n;
    logic              done_n, err_n;
    logic              beat;
    logic              served;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              v1, e1;
    logic [DATA_W-1:0] d1;

    assign beat      = (state == LOAD) && ld_valid && !load_abort;
    assign served    = (state == RUN) && (rd_addr < DEPTH_A);
    assign ld_ready  = (state == LOAD);
    assign load_busy = (state == LOAD);
    assign dbg_state = state;

    // Next-state logic for the load FSM, including pointer/count updates.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        cnt_n   = cnt;
        len_n   = len_q;
        done_n  = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE, RUN: begin
                if (load_start) begin
                    if ((load_len == '0) || (load_base >= DEPTH_A)) begin
                        err_n = 1'b1;
                    end else begin
                        state_n = LOAD;
                        ptr_n   = load_base;
                        cnt_n   = '0;
                        len_n   = load_len;
                    end
                end
            end
            LOAD: begin
                if (load_abort) begin
                    state_n = IDLE;
                end else if (ld_valid) begin
                    ptr_n = (ptr == LAST_A) ? '0 : ptr + ONE_A;
                    cnt_n = cnt + ONE_A;
                    if (cnt == len_q - ONE_A) begin
                        state_n = RUN;
                        done_n  = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // FSM state, load bookkeeping and the one-cycle status pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            len_q     <= '0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            cnt       <= cnt_n;
            len_q     <= len_n;
            load_done <= done_n;
            load_err  <= err_n;
        end
    end

    // Memory write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (beat) begin
            mem[ptr[IDX_W-1:0]] <= ld_data;
        end
    end

    // First fetch stage: gate on state/range, hold data and error between requests.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1 <= 1'b0;
            e1 <= 1'b0;
            d1 <= '0;
        end else begin
            v1 <= rd_en;
            if (rd_en) begin
                e1 <= !served;
                d1 <= served ? mem[rd_addr[IDX_W-1:0]] : NOP_WORD;
            end
        end
    end

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic              v2, e2;
            logic [DATA_W-1:0] d2;

            // Optional output register stage for two-cycle fetch latency.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    v2 <= 1'b0;
                    e2 <= 1'b0;
                    d2 <= '0;
                end else begin
                    v2 <= v1;
                    if (v1) begin
                        e2 <= e1;
                        d2 <= d1;
                    end
                end
            end

            assign rd_valid = v2;
            assign rd_err   = e2;
            assign rd_data  = d2;
        end else begin : g_lat1
            assign rd_valid = v1;
            assign rd_err   = e1;
            assign rd_data  = d1;
        end
    endgenerate

endmodule

// File: tb/tb_instr_mem_stream.sv
// Directed bench for instr_mem_stream: table-driven pipelined read-backs plus
// hand-written load, wrap, abort, error and reset sequences.
module tb_instr_mem_stream;

    localparam int          DW    = 32;
    localparam int          DEPTH = 256;
    localparam int          AW    = 32;
    localparam int          RL    = 1;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    localparam logic [1:0]  S_IDLE = 2'd0;
    localparam logic [1:0]  S_LOAD = 2'd1;
    localparam logic [1:0]  S_RUN  = 2'd2;

    logic          clk;
    logic          reset;
    logic          load_start;
    logic          load_abort;
    logic [AW-1:0] load_base;
    logic [AW-1:0] load_len;
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          ld_ready;
    logic          load_busy;
    logic          load_done;
    logic          load_err;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_err;
    logic [1:0]    dbg_state;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
    } rd_vec_t;

    logic [31:0] mem_m [DEPTH];
    logic        m_run;
    int          n_cmp;
    int          n_fail;
    rd_vec_t     tbl[$];

    instr_mem_stream #(
        .DATA_W  (DW),
        .DEPTH   (DEPTH),
        .ADDR_W  (AW),
        .READ_LAT(RL),
        .NOP_WORD(NOP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .load_start(load_start),
        .load_abort(load_abort),
        .load_base (load_base),
        .load_len  (load_len),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .load_busy (load_busy),
        .load_done (load_done),
        .load_err  (load_err),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_err    (rd_err),
        .dbg_state (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, ".ld_ready"},  ld_ready,  0);
        chk({name, ".load_busy"}, load_busy, 0);
        chk({name, ".load_done"}, load_done, 0);
        chk({name, ".load_err"},  load_err,  0);
        chk({name, ".rd_valid"},  rd_valid,  0);
        chk({name, ".rd_data"},   rd_data,   0);
        chk({name, ".rd_err"},    rd_err,    0);
        chk({name, ".state"},     dbg_state, S_IDLE);
    endtask

    task automatic start_load(input logic [31:0] base, input logic [31:0] len);
        load_start = 1'b1;
        load_base  = base;
        load_len   = len;
        tick();
        load_start = 1'b0;
        // Scramble the request fields: they must have been captured.
        load_base  = 32'h0000_0077;
        load_len   = 32'd99;
    endtask

    // Streaming load with ld_valid held high; checks the done pulse timing.
    task automatic do_load(input string name, input logic [31:0] base,
                           input logic [31:0] len, input logic [31:0] tag);
        start_load(base, len);
        chk({name, ".busy"},  load_busy, 1);
        chk({name, ".ready"}, ld_ready,  1);
        for (int k = 0; k < int'(len); k++) begin
            ld_valid = 1'b1;
            ld_data  = tag + k;
            mem_m[(int'(base) + k) % DEPTH] = tag + k;
            tick();
            if (k == int'(len) - 1) begin
                chk({name, ".done_last"},  load_done, 1);
                chk({name, ".ready_last"}, ld_ready,  0);
                chk({name, ".state_last"}, dbg_state, S_RUN);
            end else if (k == 0) begin
                chk({name, ".done_first"}, load_done, 0);
            end
        end
        ld_valid = 1'b0;
        m_run    = 1'b1;
        tick();
        chk({name, ".done_clear"}, load_done, 0);
    endtask

    // Single fetch compared against the bench's memory/state model.
    task automatic rd_check(input string name, input logic [31:0] addr);
        logic        e_err;
        logic [31:0] e_data;
        e_err  = !m_run || (addr >= DEPTH);
        e_data = e_err ? NOP : mem_m[addr];
        rd_en   = 1'b1;
        rd_addr = addr;
        tick();
        rd_en = 1'b0;
        repeat (RL - 1) tick();
        chk({name, ".valid"}, rd_valid, 1);
        chk({name, ".data"},  rd_data,  e_data);
        chk({name, ".err"},   rd_err,   e_err);
    endtask

    // Back-to-back fetches from the vector table; results checked RL cycles later.
    task automatic run_table(input string name);
        int n;
        int j;
        n = tbl.size();
        for (int i = 0; i < n + RL; i++) begin
            if (i < n) begin
                rd_en   = 1'b1;
                rd_addr = tbl[i].addr;
            end else begin
                rd_en = 1'b0;
            end
            tick();
            j = i - RL + 1;
            if (j >= 0 && j < n) begin
                chk($sformatf("%s[%0d].valid", name, j), rd_valid, 1);
                chk($sformatf("%s[%0d].data", name, j),  rd_data,  tbl[j].data);
                chk($sformatf("%s[%0d].err", name, j),   rd_err,   tbl[j].err);
            end
        end
        rd_en = 1'b0;
        tick();
        chk({name, ".idle_valid"}, rd_valid, 0);
        chk({name, ".hold_data"},  rd_data,  tbl[n-1].data);
    endtask

    initial begin
        int k;
        logic pat [7];
        n_cmp      = 0;
        n_fail     = 0;
        m_run      = 1'b0;
        reset      = 1'b0;
        load_start = 1'b0;
        load_abort = 1'b0;
        load_base  = '0;
        load_len   = '0;
        ld_valid   = 1'b0;
        ld_data    = '0;
        rd_en      = 1'b0;
        rd_addr    = '0;

        // Reset state
        #2;
        chk_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        tick();
        chk_reset_outputs("post_reset");

        // 1. Stream 17 words from address 0, read back pipelined
        do_load("load17", 32'd0, 32'd17, 32'hA000_0000);
        tbl.delete();
        for (int i = 0; i < 17; i++) tbl.push_back('{addr: i, data: 32'hA000_0000 + i, err: 1'b0});
        tbl.push_back('{addr: 32'd300, data: NOP, err: 1'b1});
        tbl.push_back('{addr: 32'd256, data: NOP, err: 1'b1});
        tbl.push_back('{addr: 32'd3,   data: 32'hA000_0003, err: 1'b0});
        run_table("tbl1");

        // 2. Wrapping load at the top of memory
        do_load("wrap", 32'd254, 32'd4, 32'hB000_0000);
        rd_check("wrap_254", 32'd254);
        rd_check("wrap_255", 32'd255);
        rd_check("wrap_0",   32'd0);
        rd_check("wrap_1",   32'd1);
        rd_check("wrap_2",   32'd2);

        // 3. Gappy ld_valid: only valid beats are written
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        start_load(32'd10, 32'd3);
        k = 0;
        for (int c = 0; c < 7; c++) begin
            ld_valid = pat[c];
            ld_data  = pat[c] ? 32'hC000_0000 + k : 32'hBAD0_0000 + c;
            if (pat[c]) begin
                mem_m[10 + k] = 32'hC000_0000 + k;
                k++;
            end
            tick();
            chk($sformatf("gap.done%0d", c), load_done, (k == 3));
            chk($sformatf("gap.busy%0d", c), load_busy, (k < 3));
        end
        ld_valid = 1'b0;
        tick();
        chk("gap.done_clear", load_done, 0);
        rd_check("gap_10", 32'd10);
        rd_check("gap_11", 32'd11);
        rd_check("gap_12", 32'd12);
        rd_check("gap_13", 32'd13);

        // 4. Fetch during LOAD (including the final-beat cycle) is rejected
        start_load(32'd40, 32'd2);
        m_run    = 1'b0;
        ld_valid = 1'b1;
        ld_data  = 32'h4000_0000;
        mem_m[40] = 32'h4000_0000;
        rd_en    = 1'b1;
        rd_addr  = 32'd0;
        tick();
        chk("rdload.valid", rd_valid, 1);
        chk("rdload.err",   rd_err,   1);
        chk("rdload.data",  rd_data,  NOP);
        ld_data  = 32'h4000_0001;
        mem_m[41] = 32'h4000_0001;
        rd_addr  = 32'd1;
        tick();
        chk("rdexit.done",  load_done, 1);
        chk("rdexit.err",   rd_err,    1);
        chk("rdexit.data",  rd_data,   NOP);
        ld_valid = 1'b0;
        rd_en    = 1'b0;
        m_run    = 1'b1;
        tick();
        rd_check("run_41",  32'd41);
        rd_check("run_300", 32'd300);

        // 5. Bad load requests, then abort after two beats
        start_load(32'd0, 32'd0);
        chk("err_len0.pulse", load_err,  1);
        chk("err_len0.state", dbg_state, S_RUN);
        tick();
        chk("err_len0.clear", load_err,  0);
        start_load(32'd256, 32'd4);
        chk("err_base.pulse", load_err,  1);
        chk("err_base.busy",  load_busy, 0);
        chk("err_base.state", dbg_state, S_RUN);
        tick();
        chk("err_base.clear", load_err,  0);
        start_load(32'd14, 32'd8);
        ld_valid = 1'b1;
        for (int b = 0; b < 2; b++) begin
            ld_data = 32'hD000_0000 + b;
            mem_m[14 + b] = 32'hD000_0000 + b;
            tick();
        end
        ld_data    = 32'hDEAD_BEEF;
        load_abort = 1'b1;
        tick();
        load_abort = 1'b0;
        ld_valid   = 1'b0;
        m_run      = 1'b0;
        chk("abort.state", dbg_state, S_IDLE);
        chk("abort.busy",  load_busy, 0);
        chk("abort.done",  load_done, 0);
        chk("abort.ready", ld_ready,  0);
        rd_check("idle_rd", 32'd14);

        // 6. Reset in the middle of a load
        start_load(32'd1, 32'd8);
        ld_valid = 1'b1;
        for (int b = 0; b < 5; b++) begin
            ld_data = 32'hE000_0000 + b;
            mem_m[1 + b] = 32'hE000_0000 + b;
            tick();
        end
        reset = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        ld_valid = 1'b0;
        #2 reset = 1'b1;
        tick();
        chk("midreset.after", dbg_state, S_IDLE);
        do_load("reload", 32'd100, 32'd1, 32'hF000_0000);

        tbl.delete();
        tbl.push_back('{addr: 32'd0,   data: 32'hB000_0002, err: 1'b0});
        tbl.push_back('{addr: 32'd1,   data: 32'hE000_0000, err: 1'b0});
        tbl.push_back('{addr: 32'd4,   data: 32'hE000_0003, err: 1'b0});
        tbl.push_back('{addr: 32'd5,   data: 32'hE000_0004, err: 1'b0});
        tbl.push_back('{addr: 32'd6,   data: 32'hA000_0006, err: 1'b0});
        tbl.push_back('{addr: 32'd12,  data: 32'hC000_0002, err: 1'b0});
        tbl.push_back('{addr: 32'd13,  data: 32'hA000_000D, err: 1'b0});
        tbl.push_back('{addr: 32'd14,  data: 32'hD000_0000, err: 1'b0});
        tbl.push_back('{addr: 32'd15,  data: 32'hD000_0001, err: 1'b0});
        tbl.push_back('{addr: 32'd16,  data: 32'hA000_0010, err: 1'b0});
        tbl.push_back('{addr: 32'd400, data: NOP,           err: 1'b1});
        tbl.push_back('{addr: 32'd100, data: 32'hF000_0000, err: 1'b0});
        tbl.push_back('{addr: 32'd255, data: 32'hB000_0001, err: 1'b0});
        run_table("tbl2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
